ndp_load_sequencer: RTL

- Input-side controller between the 32-bit AXI4-Stream DMA channel (RAM -> NDP) and the NDP systolic datapath.
- Parses a one-beat header, unpacks one weight (B) vector, then a series of activation (A) vectors.
- Issues the weight load, then hands each activation vector to the array with a valid/ready handshake.
- Checks packet framing against tlast and reports completion and errors.

---
 rtl/ndp_pkg.sv | 29 ++
 rtl/ndp_load_sequencer_if.sv | 12 +
 rtl/ndp_beat_packer.sv | 35 +++
 rtl/ndp_load_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ndp_pkg.sv
// rtl/ndp_pkg.sv - shared state encoding, default geometry and error bit indices
package ndp_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ARR_WIDTH  = 4;
    localparam int DEF_ARR_HEIGHT = 4;
    localparam int DEF_SYS_WIDTH  = 16;
    localparam int DEF_SYS_HEIGHT = 1;
    localparam int DEF_AXIS_WIDTH = 32;
    localparam int DEF_CNT_BITS   = 16;

    localparam int A_BITS  = DEF_SYS_HEIGHT * DEF_ARR_HEIGHT * DEF_WIDTH;
    localparam int B_BITS  = DEF_SYS_WIDTH * DEF_ARR_WIDTH * DEF_WIDTH;
    localparam int A_BEATS = A_BITS / DEF_AXIS_WIDTH;
    localparam int B_BEATS = B_BITS / DEF_AXIS_WIDTH;

    localparam int ERR_EARLY_TLAST = 0;
    localparam int ERR_FRAMING     = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_DRAIN  = 3'd5
    } ndp_state_e;

endpackage

// File: rtl/ndp_load_sequencer_if.sv
// rtl/ndp_load_sequencer_if.sv - input stream bundle feeding the load sequencer
interface ndp_load_sequencer_if #(
    parameter int AXIS_WIDTH = 32
);
    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/ndp_beat_packer.sv
// rtl/ndp_beat_packer.sv - gathers stream beats into one wide vector, first beat lands lowest
module ndp_beat_packer #(
    parameter int TOTAL_BITS = 64,
    parameter int BEAT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  beat_valid,
    input  logic [BEAT_BITS-1:0]  beat_data,
    output logic [TOTAL_BITS-1:0] data,
    output logic                  complete
);
    localparam int BEATS    = TOTAL_BITS / BEAT_BITS;
    localparam int IDX_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [IDX_BITS-1:0]             idx;
    logic [TOTAL_BITS+BEAT_BITS-1:0] shifted;

    // New beats enter at the top and slide down, so after BEATS beats the first sits at bit 0.
    assign shifted  = {beat_data, data} >> BEAT_BITS;
    assign complete = beat_valid && (idx == IDX_BITS'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            data <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (beat_valid) begin
            data <= shifted[TOTAL_BITS-1:0];
            idx  <= complete ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/ndp_load_sequencer.sv
// rtl/ndp_load_sequencer.sv - parses header, loads weight vector, issues activation vectors
module ndp_load_sequencer
    import ndp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_WIDTH  = 4,
    parameter int ARR_HEIGHT = 4,
    parameter int SYS_WIDTH  = 16,
    parameter int SYS_HEIGHT = 1,
    parameter int AXIS_WIDTH = 32,
    parameter int CNT_BITS   = 16,
    localparam int A_VEC_BITS = SYS_HEIGHT * ARR_HEIGHT * WIDTH,
    localparam int B_VEC_BITS = SYS_WIDTH * ARR_WIDTH * WIDTH
) (
    input  logic                   axi_aclk,
    input  logic                   axi_areset,
    ndp_load_sequencer_if.slave    s_axis,
    output logic [B_VEC_BITS-1:0]  b_data,
    output logic                   b_load,
    output logic [A_VEC_BITS-1:0]  a_data,
    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [CNT_BITS-1:0]    step_count,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err
);
    ndp_state_e         state, state_nxt;
    logic [CNT_BITS-1:0] n_vec;
    logic [CNT_BITS-1:0] hdr_n;
    logic [CNT_BITS-1:0] step_inc;
    logic                tready_q;
    logic                drain_pend;
    logic                fire, hdr_fire, b_fire, a_fire;
    logic                b_complete, a_complete;
    logic                hdr_zero, final_step, a_abort, handshake;

    assign s_axis.tready = tready_q;

    assign fire       = s_axis.tvalid && tready_q;
    assign hdr_fire   = fire && (state == ST_IDLE);
    assign b_fire     = fire && (state == ST_LOAD_B);
    assign a_fire     = fire && (state == ST_LOAD_A);
    assign hdr_n      = s_axis.tdata[CNT_BITS-1:0];
    assign hdr_zero   = (hdr_n == '0);
    assign step_inc   = step_count + 1'b1;
    assign final_step = (step_inc == n_vec);
    assign handshake  = a_valid && a_ready;
    // Only the last beat of the last vector may carry tlast.
    assign a_abort    = s_axis.tlast && !(a_complete && final_step);

    ndp_beat_packer #(
        .TOTAL_BITS (B_VEC_BITS),
        .BEAT_BITS  (AXIS_WIDTH)
    ) u_b_packer (
        .clk        (axi_aclk),
        .rst        (axi_areset),
        .clear      (hdr_fire),
        .beat_valid (b_fire),
        .beat_data  (s_axis.tdata),
        .data       (b_data),
        .complete   (b_complete)
    );

    ndp_beat_packer #(
        .TOTAL_BITS (A_VEC_BITS),
        .BEAT_BITS  (AXIS_WIDTH)
    ) u_a_packer (
        .clk        (axi_aclk),
        .rst        (axi_areset),
        .clear      (hdr_fire),
        .beat_valid (a_fire),
        .beat_data  (s_axis.tdata),
        .data       (a_data),
        .complete   (a_complete)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hdr_fire) begin
                    if (hdr_zero)          state_nxt = s_axis.tlast ? ST_IDLE : ST_DRAIN;
                    else if (s_axis.tlast) state_nxt = ST_IDLE;
                    else                   state_nxt = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (b_fire) begin
                    if (s_axis.tlast)    state_nxt = ST_IDLE;
                    else if (b_complete) state_nxt = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (a_fire) begin
                    if (a_abort)         state_nxt = ST_IDLE;
                    else if (a_complete) state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    if (drain_pend)      state_nxt = ST_DRAIN;
                    else if (final_step) state_nxt = ST_DONE;
                    else                 state_nxt = ST_LOAD_A;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_DRAIN: if (fire && s_axis.tlast) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state      <= ST_IDLE;
            tready_q   <= 1'b0;
            a_valid    <= 1'b0;
            b_load     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= '0;
            step_count <= '0;
            n_vec      <= '0;
            drain_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            tready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD_B) ||
                        (state_nxt == ST_LOAD_A) || (state_nxt == ST_DRAIN);
            a_valid  <= (state_nxt == ST_ISSUE);
            done     <= (state_nxt == ST_DONE);
            busy     <= (state_nxt != ST_IDLE);
            b_load   <= b_fire && !s_axis.tlast && b_complete;

            if (hdr_fire) begin
                n_vec                <= hdr_n;
                step_count           <= '0;
                drain_pend           <= 1'b0;
                err[ERR_FRAMING]     <= hdr_zero;
                err[ERR_EARLY_TLAST] <= !hdr_zero && s_axis.tlast;
            end
            if (b_fire && s_axis.tlast) begin
                err[ERR_EARLY_TLAST] <= 1'b1;
            end
            if (a_fire && a_abort) begin
                err[ERR_EARLY_TLAST] <= 1'b1;
            end
            // Final vector without tlast: still issue it, then skip whatever the sender appended.
            if (a_fire && a_complete && final_step && !s_axis.tlast) begin
                err[ERR_FRAMING] <= 1'b1;
                drain_pend       <= 1'b1;
            end
            if (handshake) begin
                step_count <= step_inc;
            end
        end
    end
endmodule
